demod_decimator: RTL and testbench

- Sits directly downstream of `Demodule` and consumes either its AM or its FM 12-bit output at the 100 MHz system clock.
- Applies a 3-stage CIC decimation by a programmable ratio R, a programmable arithmetic right shift and saturation.
- Delivers 16-bit signed audio-rate samples through a valid/ready output port to the audio sink (DAC/I2S stage).
- Reports dropped samples and clipping through sticky flags.

---
 rtl/demod_decimator.sv | 110 +++++++++++
 tb/tb_demod_decimator.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/demod_decimator.sv
// Third-order CIC decimator for the Demodule AM/FM output: programmable ratio,
// arithmetic scaling and saturation, delivered through a valid/ready register.
module demod_decimator #(
  parameter int INPUT_WIDTH  = 12,
  parameter int OUTPUT_WIDTH = 16,
  parameter int RATE_WIDTH   = 12,
  parameter int ACC_WIDTH    = 48
) (
  input  logic                    clk_in,
  input  logic                    sys_rst_n,
  input  logic [INPUT_WIDTH-1:0]  wave_in,
  input  logic                    in_en,
  input  logic [RATE_WIDTH-1:0]   rate,
  input  logic [5:0]              shift,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  output logic                    saturated
);

  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V =
    {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] x, i1, i2, i3, i1_nx, i2_nx, i3_nx;
  logic signed [ACC_WIDTH-1:0] d0, d0_prev, c1, c1_prev, c2, c2_prev, c3, scaled;
  logic [RATE_WIDTH-1:0]       rate_q, r_eff, cnt;
  logic [5:0]                  sh_eff;
  logic [3:0]                  stb;
  logic                        boundary, clip;
  logic [OUTPUT_WIDTH-1:0]     sat_val;

  always_comb begin
    // Offset binary to two's complement: invert MSB, then sign-extend.
    x = {{(ACC_WIDTH-INPUT_WIDTH){~wave_in[INPUT_WIDTH-1]}},
         ~wave_in[INPUT_WIDTH-1], wave_in[INPUT_WIDTH-2:0]};
    i1_nx = i1 + x;
    i2_nx = i2 + i1_nx;
    i3_nx = i3 + i2_nx;
    r_eff = (rate_q < RATE_WIDTH'(2)) ? RATE_WIDTH'(2) : rate_q;
    boundary = in_en && (cnt == r_eff - RATE_WIDTH'(1));
    sh_eff = (32'(shift) >= ACC_WIDTH) ? 6'(ACC_WIDTH-1) : shift;
    scaled = c3 >>> sh_eff;
    clip = 1'b0;
    sat_val = scaled[OUTPUT_WIDTH-1:0];
    if (scaled > MAX_V) begin
      clip    = 1'b1;
      sat_val = MAX_V[OUTPUT_WIDTH-1:0];
    end else if (scaled < MIN_V) begin
      clip    = 1'b1;
      sat_val = MIN_V[OUTPUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!sys_rst_n) begin
      i1 <= '0; i2 <= '0; i3 <= '0;
      d0 <= '0; d0_prev <= '0;
      c1 <= '0; c1_prev <= '0;
      c2 <= '0; c2_prev <= '0;
      c3 <= '0;
      cnt       <= '0;
      stb       <= '0;
      rate_q    <= rate;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      saturated <= 1'b0;
    end else begin
      if (in_en) begin
        i1  <= i1_nx;
        i2  <= i2_nx;
        i3  <= i3_nx;
        cnt <= boundary ? '0 : cnt + RATE_WIDTH'(1);
      end
      if (boundary) begin
        d0     <= i3_nx;
        rate_q <= rate;
      end
      // Each comb stage fires one clock after the previous one, once per frame.
      stb <= {stb[2:0], boundary};
      if (stb[0]) begin
        c1      <= d0 - d0_prev;
        d0_prev <= d0;
      end
      if (stb[1]) begin
        c2      <= c1 - c1_prev;
        c1_prev <= c1;
      end
      if (stb[2]) begin
        c3      <= c2 - c2_prev;
        c2_prev <= c2;
      end
      if (stb[3]) begin
        if (clip) saturated <= 1'b1;
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end else begin
          out_data  <= sat_val;
          out_valid <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demod_decimator.sv
// Directed bench for demod_decimator: DC gain, latency, backpressure, rate
// handling, mid-frame reset, gapped input and saturation.
module tb_demod_decimator;

  logic        clk_in;
  logic        sys_rst_n;
  logic [11:0] wave_in;
  logic        in_en;
  logic [11:0] rate;
  logic [5:0]  shift;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        saturated;

  int n_assert = 0;
  int n_fail   = 0;

  demod_decimator #(
    .INPUT_WIDTH (12),
    .OUTPUT_WIDTH(16),
    .RATE_WIDTH  (12),
    .ACC_WIDTH   (48)
  ) dut (
    .clk_in   (clk_in),
    .sys_rst_n(sys_rst_n),
    .wave_in  (wave_in),
    .in_en    (in_en),
    .rate     (rate),
    .shift    (shift),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun),
    .saturated(saturated)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    sys_rst_n = 1'b0;
    tick(n);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    sys_rst_n = 1'b0; wave_in = 12'hC00; in_en = 1'b1;
    rate = 12'd4; shift = 6'd6; out_ready = 1'b1;

    // DC gain and latency: R=4, x=+1024, gain 64 >>> 6
    tick(3);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_ovr",   32'(overrun),   32'd0);
    chk("rst_sat",   32'(saturated), 32'd0);
    sys_rst_n = 1'b1;                 // cycle 0
    tick(7);
    chk("lat_pre",   32'(out_valid), 32'd0);
    tick(1);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("dc_out1",   32'(out_data),  32'd320);
    tick(1);
    chk("dc_xfer",   32'(out_valid), 32'd0);
    tick(3);
    chk("dc_out2",   32'(out_data),  32'd960);
    tick(4);
    chk("dc_out3",   32'(out_data),  32'd1024);
    tick(4);
    chk("dc_out4",   32'(out_data),  32'd1024);
    chk("dc_valid4", 32'(out_valid), 32'd1);
    chk("dc_sat",    32'(saturated), 32'd0);
    chk("dc_ovr",    32'(overrun),   32'd0);

    // Backpressure: hold first result, drop second
    out_ready = 1'b0;
    do_reset(2);                      // cycle 0
    tick(8);
    chk("bp_valid1", 32'(out_valid), 32'd1);
    chk("bp_data1",  32'(out_data),  32'd320);
    tick(4);
    chk("bp_hold",   32'(out_data),  32'd320);
    chk("bp_ovr",    32'(overrun),   32'd1);
    chk("bp_vhold",  32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick(1);
    chk("bp_fall",   32'(out_valid), 32'd0);
    out_ready = 1'b0;
    tick(3);
    chk("bp_next_v", 32'(out_valid), 32'd1);
    chk("bp_next_d", 32'(out_data),  32'd1024);
    tick(3);
    out_ready = 1'b1;                 // transfer coincides with next result
    tick(1);
    chk("bp_simul",  32'(out_valid), 32'd1);
    out_ready = 1'b0;

    // Reset mid-frame after two samples, then 4 -> 8 rate change
    tick(2);
    sys_rst_n = 1'b0;
    in_en = 1'b0;
    tick(1);
    chk("mr_valid",  32'(out_valid), 32'd0);
    chk("mr_data",   32'(out_data),  32'd0);
    chk("mr_ovr",    32'(overrun),   32'd0);
    sys_rst_n = 1'b1; in_en = 1'b1; out_ready = 1'b1;   // cycle 0
    tick(1);
    rate = 12'd8;
    tick(6);
    chk("rc_pre",    32'(out_valid), 32'd0);
    tick(1);
    chk("rc_v1",     32'(out_valid), 32'd1);
    chk("rc_d1",     32'(out_data),  32'd320);
    tick(4);
    chk("rc_not4",   32'(out_valid), 32'd0);
    tick(3);
    chk("rc_pre2",   32'(out_valid), 32'd0);
    tick(1);
    chk("rc_v2",     32'(out_valid), 32'd1);
    chk("rc_d2",     32'(out_data),  32'd4864);

    // rate=1 behaves as R=2: gain 8 >>> 3
    rate = 12'd1; shift = 6'd3;
    do_reset(2);                      // cycle 0
    tick(5);
    chk("r1_pre",    32'(out_valid), 32'd0);
    tick(1);
    chk("r1_d1",     32'(out_data),  32'd512);
    chk("r1_v1",     32'(out_valid), 32'd1);
    tick(2);
    chk("r1_d2",     32'(out_data),  32'd1024);
    tick(2);
    chk("r1_d3",     32'(out_data),  32'd1024);

    // Gapped input: in_en every 3rd cycle, R=8, shift 9
    rate = 12'd8; shift = 6'd9;
    do_reset(2);
    for (int c = 0; c <= 74; c++) begin
      in_en = (c % 3 == 0);
      if (c == 25) chk("gap_pre",  32'(out_valid), 32'd0);
      if (c == 26) chk("gap_v1",   32'(out_valid), 32'd1);
      if (c == 26) chk("gap_d1",   32'(out_data),  32'd240);
      if (c == 49) chk("gap_pre2", 32'(out_valid), 32'd0);
      if (c == 50) chk("gap_d2",   32'(out_data),  32'd912);
      if (c == 74) chk("gap_v3",   32'(out_valid), 32'd1);
      if (c == 74) chk("gap_d3",   32'(out_data),  32'd1024);
      tick(1);
    end
    in_en = 1'b1;

    // Saturation: full-scale negative at R=4095, then shift 36
    wave_in = 12'h000; rate = 12'd4095; shift = 6'd0;
    do_reset(2);                      // cycle 0
    tick(12289);
    chk("sat_v",     32'(out_valid), 32'd1);
    chk("sat_d",     32'(out_data),  32'h8000);
    chk("sat_flag",  32'(saturated), 32'd1);
    shift = 6'd36;
    tick(4095);
    chk("sh36_v",    32'(out_valid), 32'd1);
    chk("sh36_d",    32'(out_data),  32'hF801);
    chk("sh36_sat",  32'(saturated), 32'd1);
    chk("sh36_ovr",  32'(overrun),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
